hazard_detection_unit: RTL and testbench



---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/hazard_detection_unit_sat_counter.sv | 20 ++
 rtl/hazard_detection_unit.sv | 131 +++++++++++++
 tb/tb_hazard_detection_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types: hazard unit states, the zero register,
// and the latch-enable bundle driven into the PC and pipeline registers.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } hdu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
    } latch_ctrl_t;

    localparam latch_ctrl_t LATCH_ALL  = '{default: 1'b1};
    localparam latch_ctrl_t LATCH_NONE = '{default: 1'b0};

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Width-parameterised saturating up-counter for performance statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Holds at all-ones instead of wrapping, so an overflowed count stays obvious.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/bubble/flush control for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory wait freezes and a memory-wait watchdog.
module hazard_detection_unit
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic [4:0]       id_ex_rt,
    input  logic             id_ex_mem_read,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hdu_state_e        state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic              flush_pending, flush_pending_next;
    logic              freeze, load_use, flush, flush_fire;
    latch_ctrl_t       ctrl;

    always_comb begin
        freeze     = dmem_req & ~dmem_ready;
        load_use   = id_ex_mem_read & (id_ex_rt != REG_ZERO) &
                     ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
        flush      = (branch_taken | flush_pending) & ~freeze;
        flush_fire = flush & (state != ERROR);
    end

    // Freeze beats flush beats load-use; a flush discards the would-be stalled instruction.
    always_comb begin
        ctrl         = LATCH_ALL;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (rst || (state == ERROR) || freeze) begin
            ctrl = LATCH_NONE;
        end else if (flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            id_ex_bubble     = 1'b1;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign id_ex_write  = ctrl.id_ex_write;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign mem_wb_write = ctrl.mem_wb_write;
    assign mem_timeout  = (state == ERROR);

    // A branch resolved during a freeze is remembered and flushed once memory releases.
    always_comb begin
        flush_pending_next = flush_pending;
        if (branch_taken && freeze) begin
            flush_pending_next = 1'b1;
        end else if (flush_fire) begin
            flush_pending_next = 1'b0;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_next    = (TIMEOUT <= 1) ? ERROR : MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            ERROR:   state_next = ERROR;
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            wait_cnt      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_next;
            wait_cnt      <= wait_cnt_next;
            flush_pending <= flush_pending_next;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (~ctrl.pc_write),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_hazard_detection_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int SAT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       if_id_rs, if_id_rt, id_ex_rt;
    logic             id_ex_mem_read, branch_taken, dmem_req, dmem_ready;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic             id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [7:0]       ctrl_obs;

    int total = 0;
    int bad   = 0;

    bit m_error, m_pending;
    int m_run, m_stalls;

    hazard_detection_unit #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .id_ex_rt      (id_ex_rt),
        .id_ex_mem_read(id_ex_mem_read),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_write   (id_ex_write),
        .ex_mem_write  (ex_mem_write),
        .mem_wb_write  (mem_wb_write),
        .id_ex_bubble  (id_ex_bubble),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .stall_cycles  (stall_cycles),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    // {pc, if_id, id_ex, ex_mem, mem_wb writes, bubble, if_id_flush, id_ex_flush}
    assign ctrl_obs = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                       id_ex_bubble, if_id_flush, id_ex_flush};

    task automatic applyStimulus(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic br, input logic req,
                                 input logic rdy);
        id_ex_mem_read = mr;
        id_ex_rt       = ex_rt;
        if_id_rs       = rs;
        if_id_rt       = rt;
        branch_taken   = br;
        dmem_req       = req;
        dmem_ready     = rdy;
    endtask

    task automatic model_clear();
        m_error   = 0;
        m_pending = 0;
        m_run     = 0;
        m_stalls  = 0;
    endtask

    // Expected controls this cycle, straight from the priority rules.
    function automatic logic [7:0] model_ctrl();
        bit frz, lu, fl;
        frz = dmem_req && !dmem_ready;
        lu  = id_ex_mem_read && (id_ex_rt != 0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
        fl  = (branch_taken || m_pending) && !frz;
        if (m_error || frz) return 8'b00000_000;
        if (fl)             return 8'b11111_011;
        if (lu)             return 8'b00111_100;
        return 8'b11111_000;
    endfunction

    // Watchdog tracked as a run length of consecutive frozen cycles.
    task automatic model_step(input logic [7:0] exp);
        bit frz, fl;
        frz = dmem_req && !dmem_ready;
        fl  = (branch_taken || m_pending) && !frz;
        if (!exp[7] && m_stalls < SAT_MAX) m_stalls++;
        if (branch_taken && frz) m_pending = 1;
        else if (fl && !m_error) m_pending = 0;
        if (!m_error) begin
            if (frz) begin
                m_run++;
                if (m_run >= TIMEOUT) m_error = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        applyStimulus(1, 8, 8, 8, 1, 0, 0);
        @(posedge clk);
        #1;
        total++;
        if (ctrl_obs !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=%b", ctrl_obs, 8'h00);
        end
        total++;
        if (stall_cycles !== '0) begin
            bad++;
            $display("[TB] FAIL reset_stall got=%0d want=0", stall_cycles);
        end
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_timeout got=%b want=0", mem_timeout);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        applyStimulus(1, 8, 8, 3, 0, 0, 0);
        #1;
        total++;
        if (ctrl_obs !== 8'b00111_100) begin
            bad++;
            $display("[TB] FAIL load_use_stall got=%b want=%b", ctrl_obs, 8'b00111_100);
        end
        @(negedge clk);
        applyStimulus(0, 8, 8, 3, 0, 0, 0);
        #1;
        total++;
        if (ctrl_obs !== 8'b11111_000) begin
            bad++;
            $display("[TB] FAIL load_use_release got=%b want=%b", ctrl_obs, 8'b11111_000);
        end
        total++;
        if (stall_cycles !== CNT_W'(1)) begin
            bad++;
            $display("[TB] FAIL load_use_count got=%0d want=1", stall_cycles);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        applyStimulus(1, 0, 8, 0, 0, 0, 0);
        #1;
        total++;
        if (ctrl_obs !== 8'b11111_000) begin
            bad++;
            $display("[TB] FAIL zero_reg_ctrl got=%b want=%b", ctrl_obs, 8'b11111_000);
        end
        @(posedge clk);
        #1;
        total++;
        if (stall_cycles !== '0) begin
            bad++;
            $display("[TB] FAIL zero_reg_count got=%0d want=0", stall_cycles);
        end
    endtask

    task automatic test_branch_during_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, (i == 1), 1, 0);
            #1;
            total++;
            if (ctrl_obs !== 8'h00) begin
                bad++;
                $display("[TB] FAIL wait_frozen[%0d] got=%b want=%b", i, ctrl_obs, 8'h00);
            end
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        #1;
        total++;
        if (ctrl_obs !== 8'b11111_011) begin
            bad++;
            $display("[TB] FAIL wait_late_flush got=%b want=%b", ctrl_obs, 8'b11111_011);
        end
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (ctrl_obs !== 8'b11111_000) begin
            bad++;
            $display("[TB] FAIL wait_single_flush got=%b want=%b", ctrl_obs, 8'b11111_000);
        end
        total++;
        if (stall_cycles !== CNT_W'(3)) begin
            bad++;
            $display("[TB] FAIL wait_count got=%0d want=3", stall_cycles);
        end
    endtask

    task automatic test_branch_load_use();
        do_reset();
        applyStimulus(1, 8, 8, 0, 1, 0, 0);
        #1;
        total++;
        if (ctrl_obs !== 8'b11111_011) begin
            bad++;
            $display("[TB] FAIL branch_load_use got=%b want=%b", ctrl_obs, 8'b11111_011);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            @(posedge clk);
            #1;
            total++;
            if (mem_timeout !== (k >= TIMEOUT)) begin
                bad++;
                $display("[TB] FAIL timeout_flag[%0d] got=%b want=%b", k, mem_timeout, (k >= TIMEOUT));
            end
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        #1;
        total++;
        if (ctrl_obs !== 8'h00 || mem_timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_hold got=%b/%b want=%b/1", ctrl_obs, mem_timeout, 8'h00);
        end
        total++;
        if (stall_cycles !== CNT_W'(6)) begin
            bad++;
            $display("[TB] FAIL timeout_count got=%0d want=6", stall_cycles);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (mem_timeout !== 1'b0 || stall_cycles !== '0) begin
            bad++;
            $display("[TB] FAIL timeout_reset got=%b/%0d want=0/0", mem_timeout, stall_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (ctrl_obs !== 8'b11111_000) begin
            bad++;
            $display("[TB] FAIL timeout_recover got=%b want=%b", ctrl_obs, 8'b11111_000);
        end
    endtask

    task automatic test_saturation_async_reset();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1, 9, 4, 9, 0, 0, 0);
            @(posedge clk);
            #1;
            total++;
            if (stall_cycles !== CNT_W'((k < SAT_MAX) ? k : SAT_MAX)) begin
                bad++;
                $display("[TB] FAIL sat_count[%0d] got=%0d want=%0d", k, stall_cycles,
                         (k < SAT_MAX) ? k : SAT_MAX);
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (stall_cycles !== '0 || ctrl_obs !== 8'h00) begin
            bad++;
            $display("[TB] FAIL async_reset got=%0d/%b want=0/%b", stall_cycles, ctrl_obs, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_random();
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_error && $urandom_range(0, 3) == 0) do_reset();
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
            #1;
            exp = model_ctrl();
            total++;
            if (ctrl_obs !== exp) begin
                bad++;
                $display("[TB] FAIL rand_ctrl[%0d] got=%b want=%b", i, ctrl_obs, exp);
            end
            @(posedge clk);
            model_step(exp);
            #1;
            total++;
            if (stall_cycles !== CNT_W'(m_stalls) || mem_timeout !== m_error) begin
                bad++;
                $display("[TB] FAIL rand_regs[%0d] got=%0d/%b want=%0d/%b", i, stall_cycles,
                         mem_timeout, m_stalls, m_error);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        model_clear();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_during_wait();
        test_branch_load_use();
        test_timeout();
        test_saturation_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
